mux32: RTL and testbench

//  32-to-1 word multiplexer used by the register file read ports and the

---
 rtl/mux32.sv | 106 ++++++++++
 tb/tb_mux32.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mux32.sv
// 32-to-1 word multiplexer built as a 5-level balanced tree of 2:1 muxes,
// with a combinational output and a registered copy for pipelined consumers.
module mux32 #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] out,
  input  logic [4:0]       select,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic [WIDTH-1:0] in9,
  input  logic [WIDTH-1:0] in10,
  input  logic [WIDTH-1:0] in11,
  input  logic [WIDTH-1:0] in12,
  input  logic [WIDTH-1:0] in13,
  input  logic [WIDTH-1:0] in14,
  input  logic [WIDTH-1:0] in15,
  input  logic [WIDTH-1:0] in16,
  input  logic [WIDTH-1:0] in17,
  input  logic [WIDTH-1:0] in18,
  input  logic [WIDTH-1:0] in19,
  input  logic [WIDTH-1:0] in20,
  input  logic [WIDTH-1:0] in21,
  input  logic [WIDTH-1:0] in22,
  input  logic [WIDTH-1:0] in23,
  input  logic [WIDTH-1:0] in24,
  input  logic [WIDTH-1:0] in25,
  input  logic [WIDTH-1:0] in26,
  input  logic [WIDTH-1:0] in27,
  input  logic [WIDTH-1:0] in28,
  input  logic [WIDTH-1:0] in29,
  input  logic [WIDTH-1:0] in30,
  input  logic [WIDTH-1:0] in31,
  input  logic             clock,
  input  logic             reset_n,
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] lvl0 [32];
  logic [WIDTH-1:0] lvl1 [16];
  logic [WIDTH-1:0] lvl2 [8];
  logic [WIDTH-1:0] lvl3 [4];
  logic [WIDTH-1:0] lvl4 [2];

  assign lvl0[0]  = in0;
  assign lvl0[1]  = in1;
  assign lvl0[2]  = in2;
  assign lvl0[3]  = in3;
  assign lvl0[4]  = in4;
  assign lvl0[5]  = in5;
  assign lvl0[6]  = in6;
  assign lvl0[7]  = in7;
  assign lvl0[8]  = in8;
  assign lvl0[9]  = in9;
  assign lvl0[10] = in10;
  assign lvl0[11] = in11;
  assign lvl0[12] = in12;
  assign lvl0[13] = in13;
  assign lvl0[14] = in14;
  assign lvl0[15] = in15;
  assign lvl0[16] = in16;
  assign lvl0[17] = in17;
  assign lvl0[18] = in18;
  assign lvl0[19] = in19;
  assign lvl0[20] = in20;
  assign lvl0[21] = in21;
  assign lvl0[22] = in22;
  assign lvl0[23] = in23;
  assign lvl0[24] = in24;
  assign lvl0[25] = in25;
  assign lvl0[26] = in26;
  assign lvl0[27] = in27;
  assign lvl0[28] = in28;
  assign lvl0[29] = in29;
  assign lvl0[30] = in30;
  assign lvl0[31] = in31;

  // Level n pairs adjacent words using select[n]; the odd word of each pair wins on 1.
  for (genvar j = 0; j < 16; j++) begin : g_l1
    assign lvl1[j] = select[0] ? lvl0[2*j+1] : lvl0[2*j];
  end
  for (genvar j = 0; j < 8; j++) begin : g_l2
    assign lvl2[j] = select[1] ? lvl1[2*j+1] : lvl1[2*j];
  end
  for (genvar j = 0; j < 4; j++) begin : g_l3
    assign lvl3[j] = select[2] ? lvl2[2*j+1] : lvl2[2*j];
  end
  for (genvar j = 0; j < 2; j++) begin : g_l4
    assign lvl4[j] = select[3] ? lvl3[2*j+1] : lvl3[2*j];
  end

  assign out = select[4] ? lvl4[1] : lvl4[0];

  // Reset clears only the registered copy; the combinational path stays live.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else          out_q <= out;
  end

endmodule

// File: tb/tb_mux32.sv
// Directed bench for mux32: combinational selection, boundary codes,
// input tracking without clocks, async reset of out_q and one-cycle lag.
module tb_mux32;

  localparam int W = 32;

  logic         clock;
  logic         reset_n;
  logic [4:0]   select;
  logic [W-1:0] din [32];
  logic [W-1:0] out;
  logic [W-1:0] out_q;

  int total;
  int bad;
  logic [W-1:0] prev;

  mux32 #(.WIDTH(W)) dut (
    .out(out), .select(select),
    .in0(din[0]),   .in1(din[1]),   .in2(din[2]),   .in3(din[3]),
    .in4(din[4]),   .in5(din[5]),   .in6(din[6]),   .in7(din[7]),
    .in8(din[8]),   .in9(din[9]),   .in10(din[10]), .in11(din[11]),
    .in12(din[12]), .in13(din[13]), .in14(din[14]), .in15(din[15]),
    .in16(din[16]), .in17(din[17]), .in18(din[18]), .in19(din[19]),
    .in20(din[20]), .in21(din[21]), .in22(din[22]), .in23(din[23]),
    .in24(din[24]), .in25(din[25]), .in26(din[26]), .in27(din[27]),
    .in28(din[28]), .in29(din[29]), .in30(din[30]), .in31(din[31]),
    .clock(clock), .reset_n(reset_n), .out_q(out_q)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tie_index();
    for (int k = 0; k < 32; k++) din[k] = W'(k);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    select  = 5'd0;
    tie_index();
    #1;
    check("reset_out_q", out_q, '0);
    check("reset_out_live", out, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: in_k = k, out follows select
    for (int s = 0; s < 32; s++) begin
      select = 5'(s);
      #20;
      check("sweep_index", out, W'(s));
    end

    // 2: in_k = ~k catches swapped select bits
    for (int k = 0; k < 32; k++) din[k] = ~W'(k);
    for (int s = 0; s < 32; s++) begin
      select = 5'(s);
      #20;
      check("sweep_inverted", out, ~W'(s));
    end

    // 3: boundary codes
    for (int k = 0; k < 32; k++) din[k] = '0;
    din[31] = 32'hFFFF_FFFF;
    select  = 5'd31;
    #3;
    check("boundary_31", out, 32'hFFFF_FFFF);
    select = 5'd0;
    #3;
    check("boundary_0", out, 32'h0000_0000);

    // 4: data change on the selected input propagates without a clock
    @(posedge clock);
    #2;
    select  = 5'd7;
    din[7]  = 32'hA5A5_A5A5;
    #1;
    check("track_a5", out, 32'hA5A5_A5A5);
    din[7] = 32'h5A5A_5A5A;
    #1;
    check("track_5a", out, 32'h5A5A_5A5A);
    din[8] = 32'h1234_5678;
    #1;
    check("unselected_in8", out, 32'h5A5A_5A5A);

    // 5: async reset mid-run with out = 9
    tie_index();
    select = 5'd9;
    @(posedge clock);
    #1;
    check("pre_reset_out_q", out_q, 32'd9);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out_q", out_q, 32'd0);
    check("reset_out_stays", out, 32'd9);
    @(posedge clock);
    #1;
    check("held_in_reset", out_q, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("released_no_edge", out_q, 32'd0);
    @(posedge clock);
    #1;
    check("first_capture", out_q, 32'd9);

    // 6: clocked sweep, out_q lags by one edge
    @(negedge clock);
    select = 5'd31;
    @(posedge clock);
    #1;
    prev = 32'd31;
    for (int s = 0; s < 32; s++) begin
      @(negedge clock);
      check("lag_before", out_q, prev);
      select = 5'(s);
      #1;
      check("lag_out", out, W'(s));
      check("lag_hold", out_q, prev);
      @(posedge clock);
      #1;
      check("lag_capture", out_q, W'(s));
      prev = W'(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
